// File: rtl/md_seq_pkg.sv
// md_seq_pkg: shared definitions for the multiply/divide sequencer.
// Holds the 3-bit MD op encodings, FSM state encodings, the stall and
// divider-start level names, and small op-classification helpers.
package md_seq_pkg;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_MADD  = 3'd2,
      MD_MADDU = 3'd3,
      MD_MSUB  = 3'd4,
      MD_MSUBU = 3'd5,
      MD_DIV   = 3'd6,
      MD_DIVU  = 3'd7
   } md_op_e;

   typedef enum logic [2:0] {
      MD_IDLE     = 3'd0,
      MD_MUL      = 3'd1,
      MD_ACC      = 3'd2,
      MD_DIV_WAIT = 3'd3,
      MD_DONE     = 3'd4
   } md_state_e;

   localparam logic        STOP      = 1'b1;
   localparam logic        NO_STOP   = 1'b0;
   localparam logic        DIV_START = 1'b1;
   localparam logic        DIV_STOP  = 1'b0;
   localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

   // DIV and DIVU go to the external divider; everything else is a multiply.
   function automatic logic md_is_div(input md_op_e op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   // Signed variants: MULT, MADD, MSUB, DIV.
   function automatic logic md_is_signed(input md_op_e op);
      return (op == MD_MULT) || (op == MD_MADD) || (op == MD_MSUB) || (op == MD_DIV);
   endfunction

   // Ops that fold the product into the current HI:LO.
   function automatic logic md_is_acc(input md_op_e op);
      return (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
   endfunction

   // Ops whose product is subtracted from HI:LO.
   function automatic logic md_is_sub(input md_op_e op);
      return (op == MD_MSUB) || (op == MD_MSUBU);
   endfunction

endpackage

// File: rtl/md_seq_if.sv
// md_seq_if: EX-side request/response and external-divider handshake of md_seq.
// slave = the sequencer's view, master = the EX stage / divider side.
interface md_seq_if;
   import md_seq_pkg::*;

   // EX request side
   logic          flush_i;
   logic          hold_i;
   logic          req_valid_i;
   md_op_e        op_i;
   logic [31:0]   opa_i;
   logic [31:0]   opb_i;
   logic [31:0]   hi_i;
   logic [31:0]   lo_i;
   // divider handshake
   logic          div_start_o;
   logic          div_annul_o;
   logic          div_signed_o;
   logic [31:0]   div_opa_o;
   logic [31:0]   div_opb_o;
   logic [63:0]   div_result_i;
   logic          div_ready_i;
   // results back to EX / ctrl
   logic          stallreq_o;
   logic          whilo_o;
   logic [31:0]   hi_o;
   logic [31:0]   lo_o;
   logic          busy_o;

   modport slave (
      input  flush_i, hold_i, req_valid_i, op_i, opa_i, opb_i, hi_i, lo_i,
             div_result_i, div_ready_i,
      output div_start_o, div_annul_o, div_signed_o, div_opa_o, div_opb_o,
             stallreq_o, whilo_o, hi_o, lo_o, busy_o
   );

   modport master (
      output flush_i, hold_i, req_valid_i, op_i, opa_i, opb_i, hi_i, lo_i,
             div_result_i, div_ready_i,
      input  div_start_o, div_annul_o, div_signed_o, div_opa_o, div_opb_o,
             stallreq_o, whilo_o, hi_o, lo_o, busy_o
   );

endinterface

// File: rtl/md_seq_mul32.sv
// md_seq_mul32: the md_mul32 combinational 32x32->64 multiplier.
// Signed products are formed as |a|*|b| with the sign fixed up afterwards,
// so a single unsigned array serves both MULT and MULTU.
module md_seq_mul32 (
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        signed_i,
   output logic [63:0] prod_o
);

   logic        neg_a;
   logic        neg_b;
   logic [31:0] abs_a;
   logic [31:0] abs_b;
   logic [63:0] mag;

   // Magnitudes, unsigned product, then restore the sign.
   always_comb begin
      neg_a  = signed_i & a_i[31];
      neg_b  = signed_i & b_i[31];
      abs_a  = neg_a ? (~a_i + 32'd1) : a_i;
      abs_b  = neg_b ? (~b_i + 32'd1) : b_i;
      mag    = {32'h0, abs_a} * {32'h0, abs_b};
      prod_o = (neg_a ^ neg_b) ? (~mag + 64'd1) : mag;
   end

endmodule

// File: rtl/md_seq.sv
// md_seq: multiply/divide sequencer beside EX; owns all HI/LO-writing
// multi-cycle ops and drives the external iterative divider.
// Optional feature macro: MD_SEQ_DIV0_BYPASS_EN -- a divide by zero skips the
// divider and completes one cycle later with HI=LO=0.
module md_seq
   import md_seq_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   md_seq_if.slave   bus
);

   md_state_e   state_q, state_d;
   md_op_e      op_q, op_d;
   logic [63:0] prod_q, prod_d;
   logic [63:0] res_q, res_d;
   logic [31:0] div_opa_q, div_opa_d;
   logic [31:0] div_opb_q, div_opb_d;
   logic        div_signed_q, div_signed_d;

   logic        mul_signed;
   logic [63:0] mul_prod;
   logic [63:0] acc_sum;
   logic        div0_bypass;

   logic        stallreq;
   logic        whilo;
   logic [63:0] hi_lo;
   logic        div_start;
   logic        div_annul;
   logic        div_signed;
   logic [31:0] div_opa;
   logic [31:0] div_opb;
   logic        complete;
   logic [63:0] result;

   assign mul_signed = md_is_signed(bus.op_i);

   md_seq_mul32 u_mul (
      .a_i      (bus.opa_i),
      .b_i      (bus.opb_i),
      .signed_i (mul_signed),
      .prod_o   (mul_prod)
   );

   // The accumulate uses whatever HI/LO EX forwards in the ACC cycle itself.
   assign acc_sum = prod_q + {bus.hi_i, bus.lo_i};

`ifdef MD_SEQ_DIV0_BYPASS_EN
   assign div0_bypass = (bus.opb_i == ZERO_WORD);
`else
   assign div0_bypass = 1'b0;
`endif

   // Next-state, register updates and all handshake outputs of the sequencer.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
      state_d      = state_q;
      op_d         = op_q;
      prod_d       = prod_q;
      res_d        = res_q;
      div_opa_d    = div_opa_q;
      div_opb_d    = div_opb_q;
      div_signed_d = div_signed_q;
      stallreq     = NO_STOP;
      whilo        = 1'b0;
      hi_lo        = 64'h0;
      div_start    = DIV_STOP;
      div_annul    = 1'b0;
      div_signed   = 1'b0;
      div_opa      = ZERO_WORD;
      div_opb      = ZERO_WORD;
      complete     = 1'b0;
      result       = 64'h0;

      // While rst is asserted every output stays at its default of zero.
      if (!rst) begin
         if (bus.flush_i) begin
            // Flush beats everything, including a divider result arriving now.
            state_d   = MD_IDLE;
            div_annul = (state_q == MD_DIV_WAIT);
         end else begin
            unique case (state_q)
               MD_IDLE: begin
                  if (bus.req_valid_i) begin
                     op_d     = bus.op_i;
                     stallreq = STOP;
                     if (md_is_div(bus.op_i) && !div0_bypass) begin
                        div_start    = DIV_START;
                        div_signed   = mul_signed;
                        div_opa      = bus.opa_i;
                        div_opb      = bus.opb_i;
                        div_signed_d = mul_signed;
                        div_opa_d    = bus.opa_i;
                        div_opb_d    = bus.opb_i;
                        state_d      = MD_DIV_WAIT;
                     end else if (md_is_div(bus.op_i)) begin
                        // Bypassed divide by zero: MUL completes with this zero product.
                        prod_d  = 64'h0;
                        state_d = MD_MUL;
                     end else begin
                        prod_d  = md_is_sub(bus.op_i) ? (~mul_prod + 64'd1) : mul_prod;
                        state_d = MD_MUL;
                     end
                  end
               end
               MD_MUL: begin
                  if (md_is_acc(op_q)) begin
                     stallreq = STOP;
                     state_d  = MD_ACC;
                  end else begin
                     complete = 1'b1;
                     result   = prod_q;
                  end
               end
               MD_ACC: begin
                  complete = 1'b1;
                  result   = acc_sum;
               end
               MD_DIV_WAIT: begin
                  div_signed = div_signed_q;
                  div_opa    = div_opa_q;
                  div_opb    = div_opb_q;
                  if (bus.div_ready_i) begin
                     complete = 1'b1;
                     result   = bus.div_result_i;
                  end else begin
                     div_start = DIV_START;
                     stallreq  = STOP;
                  end
               end
               MD_DONE: begin
                  // EX is still held on this instruction: replay the result, never restart.
                  whilo = 1'b1;
                  hi_lo = res_q;
                  if (!bus.hold_i) state_d = MD_IDLE;
               end
               default: state_d = MD_IDLE;
            endcase

            if (complete) begin
               whilo   = 1'b1;
               hi_lo   = result;
               res_d   = result;
               state_d = bus.hold_i ? MD_DONE : MD_IDLE;
            end
         end
      end
   end

   // State and datapath registers, synchronously reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (rst) begin
         state_q      <= MD_IDLE;
         op_q         <= MD_MULT;
         prod_q       <= 64'h0;
         res_q        <= 64'h0;
         div_opa_q    <= ZERO_WORD;
         div_opb_q    <= ZERO_WORD;
         div_signed_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         prod_q       <= prod_d;
         res_q        <= res_d;
         div_opa_q    <= div_opa_d;
         div_opb_q    <= div_opb_d;
         div_signed_q <= div_signed_d;
      end
   end

   assign bus.stallreq_o   = stallreq;
   assign bus.whilo_o      = whilo;
   assign bus.hi_o         = hi_lo[63:32];
   assign bus.lo_o         = hi_lo[31:0];
   assign bus.div_start_o  = div_start;
   assign bus.div_annul_o  = div_annul;
   assign bus.div_signed_o = div_signed;
   assign bus.div_opa_o    = div_opa;
   assign bus.div_opb_o    = div_opb;
   assign bus.busy_o       = !rst && (state_q != MD_IDLE);

endmodule

// File: tb/tb_md_seq.sv
// tb_md_seq: self-checking bench for md_seq. The divider is modelled by the
// bench (ready after a chosen number of cycles) and all expected timing and
// HI/LO values come from a plain-arithmetic reference model.
// Build with MD_SEQ_DIV0_BYPASS_EN defined to exercise the divide-by-zero bypass.
module tb_md_seq;
   import md_seq_pkg::*;

`ifdef MD_SEQ_DIV0_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   md_seq_if bus ();

   md_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic bit ref_signed(input md_op_e op);
      return op inside {MD_MULT, MD_MADD, MD_MSUB, MD_DIV};
   endfunction

   function automatic logic [63:0] ref_prod(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      if (ref_signed(op)) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         return sa * sb;
      end
      return {32'h0, a} * {32'h0, b};
   endfunction

   // The bench's divider: {remainder, quotient}, truncating toward zero.
   function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 32'h0) return {a, 32'hFFFF_FFFF};
      if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'h0, a});
         sb = longint'({32'h0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   function automatic logic [63:0] ref_result(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                                              input logic [31:0] hi, input logic [31:0] lo);
      case (op)
         MD_MULT, MD_MULTU: return ref_prod(op, a, b);
         MD_MADD, MD_MADDU: return {hi, lo} + ref_prod(op, a, b);
         MD_MSUB, MD_MSUBU: return {hi, lo} - ref_prod(op, a, b);
         default:           return (BYPASS && b == 32'h0) ? 64'h0 : ref_div(op == MD_DIV, a, b);
      endcase
   endfunction

   function automatic bit uses_divider(input md_op_e op, input logic [31:0] b);
      return (op inside {MD_DIV, MD_DIVU}) && !(BYPASS && b == 32'h0);
   endfunction

   function automatic int ref_latency(input md_op_e op, input logic [31:0] b, input int dlat);
      if (op inside {MD_MULT, MD_MULTU}) return 2;
      if (op inside {MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU}) return 3;
      return uses_divider(op, b) ? 1 + dlat : 2;
   endfunction

   // {stallreq, whilo, busy, div_start, div_annul, hi, lo}
   function automatic logic [68:0] observe();
      return {bus.stallreq_o, bus.whilo_o, bus.busy_o, bus.div_start_o, bus.div_annul_o,
              bus.hi_o, bus.lo_o};
   endfunction

   task automatic idle_inputs();
      bus.flush_i      = 1'b0;
      bus.hold_i       = 1'b0;
      bus.req_valid_i  = 1'b0;
      bus.op_i         = MD_MULT;
      bus.opa_i        = 32'h0;
      bus.opb_i        = 32'h0;
      bus.hi_i         = 32'h0;
      bus.lo_i         = 32'h0;
      bus.div_ready_i  = 1'b0;
      bus.div_result_i = 64'h0;
   endtask

   // One md op from request to return-to-idle; hold_n cycles of hold_i at completion.
   task automatic run_op(input string name, input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] hi, input logic [31:0] lo, input int dlat, input int hold_n);
      int          s;
      bit          ud;
      logic [63:0] res;
      logic [68:0] obs, exp;
      s   = ref_latency(op, b, dlat) - 1;
      ud  = uses_divider(op, b);
      res = ref_result(op, a, b, hi, lo);
      bus.op_i  = op;
      bus.opa_i = a;
      bus.opb_i = b;
      for (int c = 0; c <= s + hold_n + 1; c++) begin
         bus.req_valid_i  = (c <= s + hold_n);
         bus.hold_i       = (c >= s) && (c < s + hold_n);
         // Forwarded HI/LO is only correct in the completion cycle.
         {bus.hi_i, bus.lo_i} = (c == s) ? {hi, lo} : ~{hi, lo};
         bus.div_ready_i  = ud && (c == dlat);
         bus.div_result_i = bus.div_ready_i ? ref_div(op == MD_DIV, a, b) : {$urandom, $urandom};
         @(negedge clk);
         obs = observe();
         exp = {c < s, (c >= s) && (c <= s + hold_n), (c >= 1) && (c <= s + hold_n), ud && (c < s), 1'b0,
                ((c >= s) && (c <= s + hold_n)) ? res : 64'h0};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got stall/whilo/busy/start/annul=%b hilo=%h, expected %b hilo=%h",
                     name, c, obs[68:64], obs[63:0], exp[68:64], exp[63:0]);
         end
         if (ud && c < s) begin
            checks++;
            if ({bus.div_signed_o, bus.div_opa_o, bus.div_opb_o} !== {op == MD_DIV, a, b}) begin
               errors++;
               $display("FAIL %s div operands cycle %0d: got %b %h %h, expected %b %h %h", name, c,
                        bus.div_signed_o, bus.div_opa_o, bus.div_opb_o, op == MD_DIV, a, b);
            end
         end
         @(posedge clk); #1;
      end
      idle_inputs();
   endtask

   // Op aborted by flush_i in cycle flush_at (flush_at <= completion cycle).
   task automatic run_flush(input string name, input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                            input int dlat, input int flush_at);
      bit          ud;
      logic [68:0] obs, exp;
      ud = uses_divider(op, b);
      bus.op_i  = op;
      bus.opa_i = a;
      bus.opb_i = b;
      for (int c = 0; c <= flush_at + 3; c++) begin
         bus.req_valid_i  = (c <= flush_at);
         bus.flush_i      = (c == flush_at);
         {bus.hi_i, bus.lo_i} = {$urandom, $urandom};
         bus.div_ready_i  = ud && (c == dlat);
         bus.div_result_i = {$urandom, $urandom};
         @(negedge clk);
         obs = observe();
         if (c < flush_at)       exp = {1'b1, 1'b0, c >= 1, ud, 1'b0, 64'h0};
         else if (c == flush_at) exp = {1'b0, 1'b0, c >= 1, 1'b0, ud && (c >= 1), 64'h0};
         else                    exp = 69'h0;
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got stall/whilo/busy/start/annul=%b hilo=%h, expected %b hilo=%h",
                     name, c, obs[68:64], obs[63:0], exp[68:64], exp[63:0]);
         end
         @(posedge clk); #1;
      end
      idle_inputs();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      idle_inputs();
      bus.req_valid_i = 1'b1;
      bus.op_i        = MD_DIV;
      bus.opa_i       = 32'd9;
      bus.opb_i       = 32'd2;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if ({observe(), bus.div_opa_o, bus.div_opb_o, bus.div_signed_o} !== 134'h0) begin
            errors++;
            $display("FAIL reset_outputs cycle %0d: got %b/%h, expected all zero", c, observe(), bus.div_opa_o);
         end
         @(posedge clk); #1;
      end
      rst = 1'b0;
      idle_inputs();
      @(negedge clk);
      checks++;
      if (observe() !== 69'h0) begin
         errors++;
         $display("FAIL reset_idle: got %h, expected 0", observe());
      end
      @(posedge clk); #1;
   endtask

   task automatic test_mult();
      run_op("mult_spec", MD_MULT, 32'hFFFF_FFFE, 32'd3, 32'h0, 32'h0, 0, 0);
      run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 0, 0);
      run_op("mult_minint", MD_MULT, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0, 0, 0);
   endtask

   task automatic test_accumulate();
      run_op("maddu_spec", MD_MADDU, 32'h8000_0000, 32'd2, 32'h0, 32'hFFFF_FFFF, 0, 0);
      run_op("msub_spec", MD_MSUB, 32'd3, 32'd4, 32'h0, 32'd20, 0, 0);
      run_op("madd_neg", MD_MADD, 32'hFFFF_FFFF, 32'd5, 32'h0, 32'd2, 0, 0);
      run_op("msubu_wrap", MD_MSUBU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 0, 0);
   endtask

   task automatic test_divide();
      run_op("div_spec", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'h0, 33, 0);
      run_op("divu_fast", MD_DIVU, 32'd1000, 32'd7, 32'h0, 32'h0, 1, 0);
      run_op("div_overflow", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0, 4, 0);
      // Divide by zero: bypassed to HI=LO=0 in 2 cycles, or sent to the divider.
      run_op("divu_by_zero", MD_DIVU, 32'd55, 32'h0, 32'h0, 32'h0, 6, 0);
      run_op("div_by_zero", MD_DIV, 32'hFFFF_0000, 32'h0, 32'h0, 32'h0, 3, 1);
   endtask

   task automatic test_hold();
      run_op("mult_hold3", MD_MULT, 32'd12345, 32'hFFFF_FF00, 32'h0, 32'h0, 0, 3);
      run_op("madd_hold1", MD_MADD, 32'd7, 32'd9, 32'h1, 32'h2, 0, 1);
      run_op("divu_hold2", MD_DIVU, 32'd77, 32'd5, 32'h0, 32'h0, 8, 2);
   endtask

   task automatic test_flush();
      run_flush("flush_div_c10", MD_DIV, 32'd100, 32'd3, 33, 10);
      run_flush("flush_div_with_ready", MD_DIVU, 32'd100, 32'd3, 5, 5);
      run_flush("flush_mult_idle", MD_MULT, 32'd3, 32'd4, 0, 0);
      run_flush("flush_mult_complete", MD_MULT, 32'd3, 32'd4, 0, 1);
      run_flush("flush_madd_acc", MD_MADD, 32'd3, 32'd4, 0, 2);
      run_flush("flush_div_idle", MD_DIV, 32'd9, 32'd2, 20, 0);
   endtask

   task automatic test_rst_mid_op();
      logic [68:0] obs;
      bus.req_valid_i = 1'b1;
      bus.op_i        = MD_DIVU;
      bus.opa_i       = 32'd500;
      bus.opb_i       = 32'd9;
      for (int c = 0; c < 8; c++) begin
         rst = (c == 5);
         if (c >= 6) bus.req_valid_i = 1'b0;
         @(negedge clk);
         obs = observe();
         checks++;
         if (c < 5) begin
            if (obs !== {1'b1, 1'b0, c >= 1, 1'b1, 1'b0, 64'h0}) begin
               errors++;
               $display("FAIL rst_mid_op run cycle %0d: got %b, expected stall+start", c, obs[68:64]);
            end
         end else if (obs !== 69'h0) begin
            errors++;
            $display("FAIL rst_mid_op cycle %0d: got %b hilo=%h, expected all zero (no annul)",
                     c, obs[68:64], obs[63:0]);
         end
         @(posedge clk); #1;
      end
      rst = 1'b0;
      idle_inputs();
   endtask

   task automatic test_random();
      md_op_e      op;
      logic [31:0] a, b, hi, lo;
      for (int i = 0; i < 40; i++) begin
         op = md_op_e'($urandom_range(0, 7));
         a  = $urandom;
         b  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
         hi = $urandom;
         lo = $urandom;
         run_op($sformatf("rand%0d_op%0d", i, op), op, a, b, hi, lo,
                $urandom_range(1, 40), $urandom_range(0, 2));
      end
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      @(posedge clk); #1;
      test_reset();
      test_mult();
      test_accumulate();
      test_divide();
      test_hold();
      test_flush();
      test_rst_mid_op();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
